// File: rtl/seg7_scan_counter.sv
// N-digit BCD up/down counter driven by a debounced push-button, with a
// time-multiplexed active-low 7-segment display driver.
module seg7_scan_counter #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned SCAN_DIV = 12000,
    parameter int unsigned DEBOUNCE = 120000,
    parameter int unsigned BLANK_LZ = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  step_in,
    input  logic                  clr,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic                  ovf
);

    localparam int unsigned CW    = 4 * DIGITS;
    localparam int unsigned DEB_W = $clog2(DEBOUNCE + 1);
    localparam int unsigned PRE_W = $clog2(SCAN_DIV);
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_deb;
    logic             r_deb_d;
    logic [DEB_W-1:0] r_deb_cnt;
    logic             w_step;

    logic [CW-1:0]    r_count;
    logic             r_ovf;
    logic [CW-1:0]    w_cnt_next;
    logic             w_carry;
    logic [3:0]       w_dig;

    logic [PRE_W-1:0] r_presc;
    logic [IDX_W-1:0] r_idx;

    logic [3:0]       w_digit;
    logic             w_blank;
    logic [6:0]       w_seg_dec;
    logic [6:0]       r_seg;
    logic [DIGITS-1:0] r_an;

    // Button synchroniser and debouncer; level only flips after a stable run.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_deb     <= 1'b0;
            r_deb_d   <= 1'b0;
            r_deb_cnt <= '0;
        end else begin
            r_sync1 <= step_in;
            r_sync2 <= r_sync1;
            r_deb_d <= r_deb;
            if (r_sync2 == r_deb) begin
                r_deb_cnt <= '0;
            end else if (r_deb_cnt == DEB_W'(DEBOUNCE - 1)) begin
                r_deb     <= r_sync2;
                r_deb_cnt <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + DEB_W'(1);
            end
        end
    end

    assign w_step = r_deb & ~r_deb_d;

    // Ripple BCD increment/decrement; a carry out of the top digit is a wrap.
    always_comb begin
        w_cnt_next = r_count;
        w_carry    = 1'b1;
        w_dig      = 4'd0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            w_dig = r_count[4*i +: 4];
            if (w_carry) begin
                if (up) begin
                    if (w_dig == 4'd9) begin
                        w_dig = 4'd0;
                    end else begin
                        w_dig   = w_dig + 4'd1;
                        w_carry = 1'b0;
                    end
                end else begin
                    if (w_dig == 4'd0) begin
                        w_dig = 4'd9;
                    end else begin
                        w_dig   = w_dig - 4'd1;
                        w_carry = 1'b0;
                    end
                end
            end
            w_cnt_next[4*i +: 4] = w_dig;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (w_step && en) begin
            r_count <= w_cnt_next;
            r_ovf   <= w_carry;
        end else begin
            r_ovf   <= 1'b0;
        end
    end

    // Scan prescaler and digit index.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (r_presc == PRE_W'(SCAN_DIV - 1)) begin
            r_presc <= '0;
            if (r_idx == IDX_W'(DIGITS - 1)) begin
                r_idx <= '0;
            end else begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end else begin
            r_presc <= r_presc + PRE_W'(1);
        end
    end

    // Digit select, leading-zero blanking and segment decode.
    always_comb begin
        w_digit = 4'd0;
        w_blank = (BLANK_LZ != 0) && (r_idx != '0);
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (IDX_W'(i) == r_idx) begin
                w_digit = r_count[4*i +: 4];
            end
            if ((IDX_W'(i) >= r_idx) && (r_count[4*i +: 4] != 4'd0)) begin
                w_blank = 1'b0;
            end
        end
        case (w_digit)
            4'd0:    w_seg_dec = 7'h40;
            4'd1:    w_seg_dec = 7'h79;
            4'd2:    w_seg_dec = 7'h24;
            4'd3:    w_seg_dec = 7'h30;
            4'd4:    w_seg_dec = 7'h19;
            4'd5:    w_seg_dec = 7'h12;
            4'd6:    w_seg_dec = 7'h02;
            4'd7:    w_seg_dec = 7'h78;
            4'd8:    w_seg_dec = 7'h00;
            4'd9:    w_seg_dec = 7'h10;
            default: w_seg_dec = 7'h7F;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg <= 7'h7F;
            r_an  <= '1;
        end else begin
            r_seg <= w_blank ? 7'h7F : w_seg_dec;
            r_an  <= ~(DIGITS'(1) << r_idx);
        end
    end

    assign seg       = r_seg;
    assign an        = r_an;
    assign count_bcd = r_count;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_seg7_scan_counter.sv
// Scoreboard bench: stimulus pushes expected count updates and display slots,
// monitors pop and compare whenever the count or the digit enable changes.
module tb_seg7_scan_counter;

    localparam int unsigned DIGITS   = 4;
    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DEBOUNCE = 3;

    logic        clk = 1'b0;
    logic        rst, en, up, step_in, clr;
    logic [6:0]  seg, seg_nb;
    logic [3:0]  an, an_nb;
    logic [15:0] count_bcd, count_nb;
    logic        ovf, ovf_nb;

    seg7_scan_counter #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE), .BLANK_LZ(1)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .step_in(step_in), .clr(clr),
        .seg(seg), .an(an), .count_bcd(count_bcd), .ovf(ovf)
    );

    seg7_scan_counter #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE), .BLANK_LZ(0)) dut_nb (
        .clk(clk), .rst(rst), .en(en), .up(up), .step_in(step_in), .clr(clr),
        .seg(seg_nb), .an(an_nb), .count_bcd(count_nb), .ovf(ovf_nb)
    );

    always #5 clk = ~clk;

    typedef struct { logic [15:0] cnt; logic ov; } cnt_exp_t;
    typedef struct { logic [3:0] an; logic [6:0] seg; logic [6:0] seg_nb; } disp_exp_t;

    cnt_exp_t  cnt_q[$];
    disp_exp_t disp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    logic        mon_en = 1'b0;
    logic [15:0] prev_cnt;
    logic [3:0]  prev_an;
    int          hold_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Count monitor: every change of count_bcd must match the next expectation.
    always @(negedge clk) begin
        cnt_exp_t e;
        if (mon_en) begin
            if (count_bcd !== prev_cnt) begin
                if (cnt_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL count_unexpected: got %h expected no change from %h", count_bcd, prev_cnt);
                end else begin
                    e = cnt_q.pop_front();
                    chk("count", 32'(count_bcd), 32'(e.cnt));
                    chk("ovf_on_update", 32'(ovf), 32'(e.ov));
                end
            end else begin
                chk("ovf_idle", 32'(ovf), 32'd0);
            end
        end
        prev_cnt <= count_bcd;
    end

    // Display monitor: each digit-enable change is compared with the next slot.
    always @(negedge clk) begin
        disp_exp_t d;
        if (mon_en) begin
            if (an !== prev_an) begin
                if (disp_q.size() != 0) begin
                    d = disp_q.pop_front();
                    chk("an", 32'(an), 32'(d.an));
                    chk("seg", 32'(seg), 32'(d.seg));
                    chk("seg_noblank", 32'(seg_nb), 32'(d.seg_nb));
                    chk("digit_hold", 32'(hold_cnt), 32'(SCAN_DIV));
                end
                hold_cnt <= 1;
            end else begin
                hold_cnt <= hold_cnt + 1;
            end
        end
        prev_an <= an;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_exp(input logic [15:0] v, input logic o);
        cnt_exp_t e;
        e.cnt = v;
        e.ov  = o;
        cnt_q.push_back(e);
        step_in = 1'b1;
        cyc(7);
        step_in = 1'b0;
        cyc(7);
    endtask

    task automatic wait_an(input logic [3:0] t);
        int k = 0;
        while (an !== t && k < 64) begin
            @(negedge clk);
            k++;
        end
        if (an !== t) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_an_timeout: got %b expected %b", an, t);
        end
    endtask

    task automatic push_disp(input logic [3:0] a, input logic [6:0] s, input logic [6:0] snb);
        disp_exp_t d;
        d.an     = a;
        d.seg    = s;
        d.seg_nb = snb;
        disp_q.push_back(d);
    endtask

    // Align to the first cycle of digit 3, then expect one full scan.
    task automatic scan4(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2, input logic [6:0] s3,
                         input logic [6:0] n0, input logic [6:0] n1, input logic [6:0] n2, input logic [6:0] n3);
        wait_an(4'b1011);
        wait_an(4'b0111);
        @(posedge clk);
        push_disp(4'b1110, s0, n0);
        push_disp(4'b1101, s1, n1);
        push_disp(4'b1011, s2, n2);
        push_disp(4'b0111, s3, n3);
        cyc(18);
        chk("disp_q_drained", 32'(disp_q.size()), 32'd0);
    endtask

    task automatic clr_exp();
        cnt_exp_t e;
        e.cnt = 16'h0000;
        e.ov  = 1'b0;
        cnt_q.push_back(e);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        cyc(2);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        cnt_exp_t e;
        rst = 1'b1; en = 1'b1; up = 1'b1; step_in = 1'b0; clr = 1'b0;
        cyc(3);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_count", 32'(count_bcd), 32'h0);
        chk("rst_ovf", 32'(ovf), 32'h0);
        rst = 1'b0;
        mon_en = 1'b1;
        cyc(1);
        chk("post_rst_an", 32'(an), 32'hE);
        chk("post_rst_seg", 32'(seg), 32'h40);

        // Long press gives exactly one step.
        e.cnt = 16'h0001; e.ov = 1'b0;
        cnt_q.push_back(e);
        step_in = 1'b1;
        cyc(10);
        step_in = 1'b0;
        cyc(8);
        scan4(7'h79, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40, 7'h40);

        // Glitching shorter than the debounce window is ignored.
        for (int i = 0; i < 20; i++) begin
            step_in = ~step_in;
            cyc(1);
        end
        step_in = 1'b0;
        cyc(8);
        chk("glitch_hold", 32'(count_bcd), 32'h0001);
        for (int v = 2; v <= 9; v++) press_exp(bcd(v), 1'b0);
        press_exp(16'h0010, 1'b0);
        scan4(7'h40, 7'h79, 7'h7F, 7'h7F, 7'h40, 7'h79, 7'h40, 7'h40);

        // Borrow across a digit and back.
        up = 1'b0;
        press_exp(16'h0009, 1'b0);
        up = 1'b1;
        press_exp(16'h0010, 1'b0);

        // Wrap in both directions.
        clr_exp();
        up = 1'b0;
        press_exp(16'h9999, 1'b1);
        press_exp(16'h9998, 1'b0);
        up = 1'b1;
        press_exp(16'h9999, 1'b0);
        press_exp(16'h0000, 1'b1);
        up = 1'b0;
        press_exp(16'h9999, 1'b1);
        up = 1'b1;
        clr_exp();
        chk("cnt_q_drained_wrap", 32'(cnt_q.size()), 32'd0);

        // Clear wins over a coincident step; disabled presses are discarded.
        for (int v = 1; v <= 42; v++) press_exp(bcd(v), 1'b0);
        e.cnt = 16'h0000; e.ov = 1'b0;
        cnt_q.push_back(e);
        step_in = 1'b1;
        cyc(5);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        cyc(2);
        step_in = 1'b0;
        cyc(8);
        chk("clr_step_count", 32'(count_bcd), 32'h0000);
        en = 1'b0;
        step_in = 1'b1;
        cyc(7);
        step_in = 1'b0;
        cyc(7);
        en = 1'b1;
        chk("en_low_hold", 32'(count_bcd), 32'h0000);
        chk("cnt_q_drained_clr", 32'(cnt_q.size()), 32'd0);

        // Count to 1234, view it, then reset mid-scan.
        for (int v = 1; v <= 1234; v++) press_exp(bcd(v), 1'b0);
        chk("count_1234", 32'(count_bcd), 32'h1234);
        scan4(7'h19, 7'h30, 7'h24, 7'h79, 7'h19, 7'h30, 7'h24, 7'h79);
        wait_an(4'b1101);
        wait_an(4'b1011);
        e.cnt = 16'h0000; e.ov = 1'b0;
        cnt_q.push_back(e);
        rst = 1'b1;
        cyc(1);
        chk("midrst_seg", 32'(seg), 32'h7F);
        chk("midrst_seg_nb", 32'(seg_nb), 32'h7F);
        chk("midrst_an", 32'(an), 32'hF);
        chk("midrst_count", 32'(count_bcd), 32'h0);
        chk("midrst_ovf", 32'(ovf), 32'h0);
        rst = 1'b0;
        cyc(1);
        chk("after_rst_an", 32'(an), 32'hE);
        chk("after_rst_seg", 32'(seg), 32'h40);
        cyc(4);
        chk("cnt_q_drained_end", 32'(cnt_q.size()), 32'd0);
        chk("disp_q_drained_end", 32'(disp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
